// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: sizes, state encoding and the
// rotating-priority search used to pick the next owner.
package arb_pkg;

   localparam int NREQ   = 4;
   localparam int IDX_W  = 2;
   localparam int HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      TURN = 2'b10
   } state_e;

   // Walks last+4 down to last+1 so the final hit is the nearest set bit after last.
   function automatic logic [IDX_W-1:0] next_winner(input logic [NREQ-1:0]  req,
                                                     input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] cand;
      next_winner = last;
      for (int i = NREQ; i >= 1; i--) begin
         cand = last + IDX_W'(i);
         if (req[cand]) next_winner = cand;
      end
   endfunction

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 decoder with enable; turns the registered grant index into grant lines.
module dec2to4 (
   input  logic [1:0] i_i,
   input  logic       i_e,
   output logic [3:0] o_z
);

   // NOTE: default assignment first so no path leaves o_z unassigned (no latch).
   always_comb begin
      o_z = '0;
      if (i_e) o_z[i_i] = 1'b1;
   end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-client round-robin arbiter with hold-limit preemption and a turnaround
// cycle between owners; grant lines come from a decoder on the registered index.
module rr_decoder_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_en,
   output logic [NREQ-1:0]  grant_oh,
   output logic             busy,
   output logic             preempt
);

   state_e              r_state;
   logic [IDX_W-1:0]    r_grant_idx;
   logic                r_grant_en;
   logic                r_busy;
   logic                r_preempt;
   logic [IDX_W-1:0]    r_last_winner;
   logic [HOLD_W-1:0]   r_hold_cnt;

   logic [IDX_W-1:0]    w_winner;
   logic                w_owner_req;
   logic                w_timeout;
   logic                w_release;

   assign w_winner    = next_winner(req, r_last_winner);
   assign w_owner_req = req[r_grant_idx];
   assign w_timeout   = (r_hold_cnt == HOLD_W'(MAX_HOLD));
   assign w_release   = done || !w_owner_req || w_timeout;

   // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_grant_idx   <= '0;
         r_grant_en    <= 1'b0;
         r_busy        <= 1'b0;
         r_preempt     <= 1'b0;
         r_last_winner <= IDX_W'(NREQ - 1);
         r_hold_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_grant_idx   <= w_winner;
                  r_grant_en    <= 1'b1;
                  r_busy        <= 1'b1;
                  r_last_winner <= w_winner;
                  r_hold_cnt    <= HOLD_W'(1);
                  r_state       <= BUSY;
               end
            end
            BUSY: begin
               if (w_release) begin
                  r_grant_en <= 1'b0;
                  r_busy     <= 1'b0;
                  // Preemption is flagged only when the timer alone forced the release.
                  r_preempt  <= w_timeout && !done && w_owner_req;
                  r_state    <= TURN;
               end else if (r_hold_cnt != '1) begin
                  r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
               end
            end
            TURN: begin
               r_preempt <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   dec2to4 u_dec (
      .i_i (r_grant_idx),
      .i_e (r_grant_en),
      .o_z (grant_oh)
   );

   assign grant_idx = r_grant_idx;
   assign grant_en  = r_grant_en;
   assign busy      = r_busy;
   assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: each step queues the hand-derived
// outputs expected after the next edge and compares them at the falling edge.
module tb_rr_decoder_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [1:0] grant_idx;
   logic       grant_en;
   logic [3:0] grant_oh;
   logic       busy;
   logic       preempt;

   typedef struct {
      logic       en;
      logic [1:0] idx;
      logic [3:0] oh;
      logic       pre;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   rr_decoder_arbiter #(.MAX_HOLD(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .grant_idx (grant_idx),
      .grant_en  (grant_en),
      .grant_oh  (grant_oh),
      .busy      (busy),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", name, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, queue what must be visible after the edge, then compare.
   task automatic cyc(input logic rst, input logic [3:0] rq, input logic dn,
                      input logic en, input logic [1:0] idx, input logic pre,
                      input string tag);
      exp_t e;
      exp_t got;
      rst_n = rst;
      req   = rq;
      done  = dn;
      e.en  = en;
      e.idx = idx;
      e.oh  = en ? (4'b0001 << idx) : 4'b0000;
      e.pre = pre;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = sb.pop_front();
      chk({got.tag, ".grant_oh"},  grant_oh,          got.oh);
      chk({got.tag, ".grant_en"},  {3'b0, grant_en},  {3'b0, got.en});
      chk({got.tag, ".grant_idx"}, {2'b0, grant_idx}, {2'b0, got.idx});
      chk({got.tag, ".busy"},      {3'b0, busy},      {3'b0, got.en});
      chk({got.tag, ".preempt"},   {3'b0, preempt},   {3'b0, got.pre});
   endtask

   initial begin
      logic [1:0] o;
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;

      // Reset, then no requests for five cycles.
      cyc(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "reset");
      for (int k = 0; k < 5; k++)
         cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "idle_noreq");

      // All request; done on the 3rd busy cycle; order 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         o = 2'(k);
         cyc(1'b1, 4'b1111, 1'b0, 1'b1, o, 1'b0, "rr_grant");
         cyc(1'b1, 4'b1111, 1'b0, 1'b1, o, 1'b0, "rr_hold1");
         cyc(1'b1, 4'b1111, 1'b0, 1'b1, o, 1'b0, "rr_hold2");
         cyc(1'b1, 4'b1111, 1'b1, 1'b0, o, 1'b0, "rr_turn");
         cyc(1'b1, 4'b1111, 1'b0, 1'b0, o, 1'b0, "rr_idle");
      end

      // Lone client 2 never releases: 16 grant cycles, preempt, turnaround, re-grant.
      cyc(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, "to_grant");
      for (int k = 0; k < 15; k++)
         cyc(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, "to_hold");
      cyc(1'b1, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, "to_preempt");
      cyc(1'b1, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b0, "to_turn");
      cyc(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, "to_regrant");

      // Timeout edge coincides with done: release without preempt.
      for (int k = 0; k < 15; k++)
         cyc(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, "tod_hold");
      cyc(1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0, "tod_release");
      cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, "tod_turn");

      // Make client 0 the last winner so client 1 wins against req=1010.
      cyc(1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, "setup_g0");
      cyc(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, "setup_rel");
      cyc(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, "setup_turn");
      cyc(1'b1, 4'b1010, 1'b0, 1'b1, 2'd1, 1'b0, "wd_grant1");
      cyc(1'b1, 4'b1010, 1'b0, 1'b1, 2'd1, 1'b0, "wd_hold1");
      // Withdraw and done together: one release, no preempt.
      cyc(1'b1, 4'b1000, 1'b1, 1'b0, 2'd1, 1'b0, "wd_release");
      cyc(1'b1, 4'b1010, 1'b0, 1'b0, 2'd1, 1'b0, "wd_turn");
      cyc(1'b1, 4'b1010, 1'b0, 1'b1, 2'd3, 1'b0, "wd_grant3");

      // Reset while client 3 owns; client 0 must win next.
      cyc(1'b0, 4'b1001, 1'b0, 1'b0, 2'd0, 1'b0, "midrst");
      cyc(1'b1, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0, "midrst_g0");

      // Release by withdrawal alone, then client 3 gets its turn.
      cyc(1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0, "wonly_rel");
      cyc(1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0, "wonly_turn");
      cyc(1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0, "wonly_g3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
